output_drain_ctrl: RTL and testbench

//  Drain engine directly downstream of output_buffer. After the PE array finishes
//  (calc_PEA done), it walks a range of output-buffer banks/rows, reads each 512-bit row
//  (1-cycle read latency) and serialises it onto a narrow external-memory write

---
 rtl/output_drain_ctrl.sv | 142 ++++++++++++++
 tb/tb_output_drain_ctrl.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/output_drain_ctrl.sv
// output_drain_ctrl: walks a bank/row range of output_buffer after the PE array
// finishes, reads each wide row (1-cycle latency) and serialises it LSB slice
// first onto a narrow valid/ready write stream toward external memory.
module output_drain_ctrl #(
  parameter int BUS_W  = 512,
  parameter int EXT_W  = 64,
  parameter int IDX_W  = 6,
  parameter int ADDR_W = 16,
  parameter int EA_W   = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [IDX_W-1:0]  bank_first,
  input  logic [IDX_W-1:0]  bank_last,
  input  logic [ADDR_W-1:0] row_count,
  input  logic [EA_W-1:0]   base_addr,
  output logic              ob_rd_en,
  output logic [IDX_W-1:0]  memory_bank_index,
  output logic [ADDR_W-1:0] memory_bank_address,
  input  logic [BUS_W-1:0]  ob_rd_data,
  output logic              ext_valid,
  input  logic              ext_ready,
  output logic [EA_W-1:0]   ext_addr,
  output logic [EXT_W-1:0]  ext_data,
  output logic              ext_last,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int BEATS  = BUS_W / EXT_W;
  localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);
  localparam logic [EA_W-1:0]   ADDR_STEP = EA_W'(EXT_W / 8);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_READ = 3'd1;
  localparam logic [2:0] S_CAPT = 3'd2;
  localparam logic [2:0] S_SEND = 3'd3;
  localparam logic [2:0] S_FIN  = 3'd4;

  logic [2:0]        state, nxt;
  logic [IDX_W-1:0]  cfg_last;
  logic [ADDR_W-1:0] cfg_rows;
  logic [IDX_W-1:0]  bank;
  logic [ADDR_W-1:0] row;
  logic [BEAT_W-1:0] beat;
  logic [BUS_W-1:0]  shreg;
  logic [EA_W-1:0]   addr;
  logic              err_q;

  logic cfg_bad, cfg_empty, beat_acc, row_end, last_row, last_bank;

  assign cfg_bad   = bank_last < bank_first;
  assign cfg_empty = cfg_bad || (row_count == '0);
  assign beat_acc  = (state == S_SEND) && ext_ready;
  assign row_end   = beat == LAST_BEAT;
  assign last_row  = row == cfg_rows - ADDR_W'(1);
  assign last_bank = bank == cfg_last;

  // All outputs decode from registered state, so ext_ready never reaches an output combinationally.
  assign ob_rd_en            = state == S_READ;
  assign memory_bank_index   = bank;
  assign memory_bank_address = row;
  assign ext_valid           = state == S_SEND;
  assign ext_addr            = addr;
  assign ext_data            = shreg[EXT_W-1:0];
  assign ext_last            = (state == S_SEND) && row_end && last_row && last_bank;
  assign busy                = (state == S_READ) || (state == S_CAPT) || (state == S_SEND);
  assign done                = (state == S_FIN) && !err_q;
  assign err                 = err_q;

  // Next-state decode; abort overrides everything including a simultaneous start.
  always_comb begin
    nxt = state;
    case (state)
      S_IDLE: if (start) nxt = cfg_empty ? S_FIN : S_READ;
      S_READ: nxt = S_CAPT;
      S_CAPT: nxt = S_SEND;
      S_SEND: if (ext_ready && row_end) nxt = (last_row && last_bank) ? S_FIN : S_READ;
      S_FIN:  nxt = S_IDLE;
      default: nxt = S_IDLE;
    endcase
    if (abort) nxt = S_IDLE;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) state <= S_IDLE;
    else      state <= nxt;
  end

  // Config latch, error flag and bank/row walk.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cfg_last <= '0;
      cfg_rows <= '0;
      bank     <= '0;
      row      <= '0;
      err_q    <= 1'b0;
    end else if (!abort) begin
      if (state == S_IDLE && start) begin
        cfg_last <= bank_last;
        cfg_rows <= row_count;
        bank     <= bank_first;
        row      <= '0;
        err_q    <= cfg_bad;
      end else if (beat_acc && row_end) begin
        // Row wraps back to 0 and bank steps; FIN is taken before the stepped bank is used.
        if (last_row) begin
          row  <= '0;
          bank <= bank + IDX_W'(1);
        end else begin
          row <= row + ADDR_W'(1);
        end
      end
    end
  end

  // Beat datapath: shift register, beat counter and running byte address.
  always_ff @(posedge clk) begin
    if (!rst) begin
      shreg <= '0;
      beat  <= '0;
      addr  <= '0;
    end else if (!abort) begin
      if (state == S_IDLE && start) begin
        addr <= base_addr;
      end else if (state == S_CAPT) begin
        shreg <= ob_rd_data;
        beat  <= '0;
      end else if (beat_acc) begin
        shreg <= shreg >> EXT_W;
        beat  <= beat + BEAT_W'(1);
        addr  <= addr + ADDR_STEP;
      end
    end
  end

endmodule

// File: tb/tb_output_drain_ctrl.sv
// Scoreboard bench for output_drain_ctrl: each run computes the expected reads and
// beats from the drain rules, a negedge monitor pops and compares them as the DUT emits.
module tb_output_drain_ctrl;

  typedef struct {
    logic [31:0] addr;
    logic [63:0] data;
    logic        last;
  } beat_t;

  logic         clk = 0;
  logic         rst;
  logic         start, abort;
  logic [5:0]   bank_first, bank_last;
  logic [15:0]  row_count;
  logic [31:0]  base_addr;
  logic         ob_rd_en;
  logic [5:0]   memory_bank_index;
  logic [15:0]  memory_bank_address;
  logic [511:0] ob_rd_data;
  logic         ext_valid, ext_ready, ext_last, busy, done, err;
  logic [31:0]  ext_addr;
  logic [63:0]  ext_data;

  output_drain_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .bank_first(bank_first), .bank_last(bank_last), .row_count(row_count),
    .base_addr(base_addr), .ob_rd_en(ob_rd_en),
    .memory_bank_index(memory_bank_index), .memory_bank_address(memory_bank_address),
    .ob_rd_data(ob_rd_data), .ext_valid(ext_valid), .ext_ready(ext_ready),
    .ext_addr(ext_addr), .ext_data(ext_data), .ext_last(ext_last),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int    checks = 0, errors = 0;
  int    cyc = 0, done_due = -1, done_seen = 0, accepted = 0;
  int    ready_mode = 0, phase = 0;
  bit    hold = 0, aborting = 0;
  beat_t held;
  beat_t bq[$];
  logic [21:0] rdq[$];

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, got, exp, cyc);
    end
  endtask

  function automatic logic [511:0] rowdata(input int b, input int r);
    logic [511:0] v;
    for (int j = 0; j < 8; j++)
      v[64*j +: 64] = {8'(b), 16'(r), 8'(j), 32'(b * 40503 + r * 2654435 + j * 977) ^ 32'h5A5A_C3C3};
    return v;
  endfunction

  function automatic logic [511:0] junk();
    logic [511:0] v;
    for (int j = 0; j < 16; j++) v[32*j +: 32] = $urandom;
    return v;
  endfunction

  // output_buffer model: 1-cycle read latency, garbage on the bus when not reading.
  always @(posedge clk) begin
    if (ob_rd_en) ob_rd_data <= rowdata(int'(memory_bank_index), int'(memory_bank_address));
    else          ob_rd_data <= junk();
  end

  // Sink back-pressure: always, 1-of-3, or random.
  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0: ext_ready = 1'b1;
      1: begin ext_ready = (phase == 2); phase = (phase + 1) % 3; end
      default: ext_ready = 1'($urandom_range(0, 1));
    endcase
  end

  // Monitor: reads, beats, handshake stability and done timing.
  always @(negedge clk) begin
    if (rst) begin
      cyc++;
      if (!aborting) begin
        if (ob_rd_en) begin
          if (rdq.size() == 0) chk("unexpected_read", 1, 0);
          else chk("rd_bank_row", 64'({memory_bank_index, memory_bank_address}), 64'(rdq.pop_front()));
        end
        if (ext_valid) begin
          if (hold) begin
            chk("stable_addr", 64'(ext_addr), 64'(held.addr));
            chk("stable_data", ext_data, held.data);
            chk("stable_last", 64'(ext_last), 64'(held.last));
          end
          if (ext_ready) begin
            hold = 0;
            if (bq.size() == 0) chk("extra_beat", 1, 0);
            else begin
              beat_t e;
              e = bq.pop_front();
              chk("beat_addr", 64'(ext_addr), 64'(e.addr));
              chk("beat_data", ext_data, e.data);
              chk("beat_last", 64'(ext_last), 64'(e.last));
              if (e.last) done_due = cyc + 1;
            end
            accepted++;
          end else begin
            hold = 1;
            held.addr = ext_addr; held.data = ext_data; held.last = ext_last;
          end
        end else if (hold) begin
          chk("valid_dropped", 0, 1);
          hold = 0;
        end
      end
      if (done) begin
        done_seen++;
        if (done_due >= 0) chk("done_timing", 64'(cyc), 64'(done_due));
      end
    end
  end

  // kind: 0 plain drain, 1 abort on beat 4 of row 1, 2 stray start mid-drain.
  task automatic run(input int f, input int l, input int rows, input logic [31:0] base,
                     input int rmode, input int kind);
    bit e_err, e_empty;
    int k, n;
    logic [511:0] rd;
    e_err   = l < f;
    e_empty = e_err || rows == 0;
    bq.delete(); rdq.delete();
    hold = 0; aborting = 0; done_due = -1; done_seen = 0; accepted = 0;
    k = 0;
    if (!e_empty)
      for (int b = f; b <= l; b++)
        for (int r = 0; r < rows; r++) begin
          rdq.push_back({6'(b), 16'(r)});
          rd = rowdata(b, r);
          for (int j = 0; j < 8; j++) begin
            bq.push_back('{addr: base + 32'(8 * k), data: rd[64*j +: 64],
                           last: (b == l && r == rows - 1 && j == 7)});
            k++;
          end
        end
    ready_mode = rmode;
    @(posedge clk); #1;
    bank_first = 6'(f); bank_last = 6'(l); row_count = 16'(rows); base_addr = base;
    start = 1;
    @(posedge clk); #1;   // accept edge T; now in cycle T+1
    start = 0;
    bank_first = 6'($urandom); bank_last = 6'($urandom);
    row_count = 16'($urandom); base_addr = $urandom;
    if (e_empty) begin
      chk("empty_busy", 64'(busy), 0);
      chk("empty_rd_en", 64'(ob_rd_en), 0);
      chk("empty_done", 64'(done), 64'(!e_err));
      chk("empty_err", 64'(err), 64'(e_err));
    end else begin
      chk("lat_rd_en_T1", 64'(ob_rd_en), 1);
      chk("lat_busy_T1", 64'(busy), 1);
      @(posedge clk); #1;
      chk("lat_valid_T2", 64'(ext_valid), 0);
      @(posedge clk); #1;
      chk("lat_valid_T3", 64'(ext_valid), 1);
    end
    if (kind == 1) begin
      n = 0;
      while (accepted < 12 && n < 500) begin @(posedge clk); #1; n++; end
      chk("abort_reach_beat", 64'(accepted), 12);
      abort = 1; aborting = 1;
      @(posedge clk); #1;
      abort = 0;
      chk("abort_valid", 64'(ext_valid), 0);
      chk("abort_busy", 64'(busy), 0);
      chk("abort_rd_en", 64'(ob_rd_en), 0);
      repeat (6) @(posedge clk);
      #1;
      chk("abort_no_done", 64'(done_seen), 0);
      chk("abort_err", 64'(err), 0);
      bq.delete(); rdq.delete(); hold = 0; aborting = 0;
      return;
    end
    if (kind == 2) begin
      n = 0;
      while (accepted < 10 && n < 500) begin @(posedge clk); #1; n++; end
      bank_first = 0; bank_last = 9; row_count = 5; base_addr = 32'hDEAD_0000;
      start = 1;
      @(posedge clk); #1;
      start = 0;
    end
    n = 0;
    while (!(bq.size() == 0 && rdq.size() == 0 && !busy) && n < 3000) begin
      @(posedge clk); #1; n++;
    end
    chk("drain_timeout", 64'(n < 3000), 1);
    repeat (3) @(posedge clk);
    #1;
    chk("beats_left", 64'(bq.size()), 0);
    chk("reads_left", 64'(rdq.size()), 0);
    chk("done_count", 64'(done_seen), 64'(!e_err));
    chk("err_flag", 64'(err), 64'(e_err));
    chk("idle_busy", 64'(busy), 0);
  endtask

  initial begin
    rst = 0; start = 1; abort = 0; ext_ready = 1;
    bank_first = 2; bank_last = 3; row_count = 2; base_addr = 32'h1000;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rd_en", 64'(ob_rd_en), 0);
    chk("rst_bank", 64'(memory_bank_index), 0);
    chk("rst_row", 64'(memory_bank_address), 0);
    chk("rst_valid", 64'(ext_valid), 0);
    chk("rst_addr", 64'(ext_addr), 0);
    chk("rst_data", ext_data, 0);
    chk("rst_last", 64'(ext_last), 0);
    chk("rst_busy", 64'(busy), 0);
    chk("rst_done", 64'(done), 0);
    chk("rst_err", 64'(err), 0);
    rst = 1; start = 0;
    repeat (4) @(posedge clk);
    #1;
    chk("post_rst_busy", 64'(busy), 0);
    chk("post_rst_valid", 64'(ext_valid), 0);

    run(2, 3, 2, 32'h1000, 0, 0);
    run(2, 3, 2, 32'h1000, 1, 0);
    run(0, 5, 0, 32'h2000, 0, 0);
    run(5, 1, 3, 32'h3000, 0, 0);
    run(2, 3, 2, 32'h1000, 0, 1);
    run(2, 3, 2, 32'h1000, 0, 0);
    run(4, 4, 3, 32'h5000, 2, 2);
    run(63, 63, 1, 32'hFFFF_FFE0, 0, 0);
    repeat (6) begin
      int f, l;
      f = $urandom_range(0, 63);
      l = f + $urandom_range(0, 2);
      if (l > 63) l = 63;
      run(f, l, $urandom_range(1, 3), $urandom & 32'hFFFF_FFF8, $urandom_range(0, 2), 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish, %0d checks, %0d errors", checks, errors);
    $fatal(1);
  end

endmodule
